// File: rtl/seq_divider.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU and the W variants.
// It retires BPC quotient bits per cycle, and handles divide-by-zero and overflow in one cycle.
module seq_divider #(
  parameter int XLEN = 64,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_quo;
  logic [XLEN:0]   r_rem;
  logic [XLEN-1:0] r_div;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_is_rem;
  logic            r_word;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_wd;
  logic            w_sgn;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_ones;
  logic [XLEN-1:0] w_min;
  logic            w_dz;
  logic            w_ovf;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic [XLEN-1:0] w_spec_raw;
  logic [XLEN-1:0] w_spec;
  logic [CW-1:0]   w_cnt0;
  logic [XLEN-1:0] w_quo0;
  logic [XLEN-1:0] w_quo;
  logic [XLEN:0]   w_rem;
  logic [XLEN-1:0] w_sel;
  logic            w_neg;
  logic [XLEN-1:0] w_val;
  logic [XLEN-1:0] w_fin;

  assign w_wd   = (XLEN == 64) && word;
  assign w_sgn  = ~op[0];
  assign w_ones = '1;

  assign w_a = w_wd ? (w_sgn ? XLEN'($signed(rs1[31:0]))
                             : XLEN'(rs1[31:0])) : rs1;
  assign w_b = w_wd ? (w_sgn ? XLEN'($signed(rs2[31:0]))
                             : XLEN'(rs2[31:0])) : rs2;

  assign w_min = w_wd ? (w_ones << 31) : (w_ones << (XLEN - 1));
  assign w_dz  = (w_b == '0);
  assign w_ovf = w_sgn && (w_a == w_min) && (w_b == w_ones);

  assign w_neg_a = w_sgn & w_a[XLEN-1];
  assign w_neg_b = w_sgn & w_b[XLEN-1];
  assign w_mag_a = w_neg_a ? -w_a : w_a;
  assign w_mag_b = w_neg_b ? -w_b : w_b;

  assign w_spec_raw = w_dz ? (op[1] ? w_a : w_ones)
                           : (op[1] ? '0 : w_a);
  assign w_spec = w_wd ? XLEN'($signed(w_spec_raw[31:0])) : w_spec_raw;

  assign w_cnt0 = w_wd ? CW'(32 / BPC) : CW'(XLEN / BPC);
  // Word dividends sit in the top half so the MSB-first shift sees them.
  assign w_quo0 = w_wd ? (w_mag_a << (XLEN - 32)) : w_mag_a;

  always_comb begin
    w_rem = r_rem;
    w_quo = r_quo;
    for (int i = 0; i < BPC; i++) begin
      w_rem = {w_rem[XLEN-1:0], w_quo[XLEN-1]};
      w_quo = w_quo << 1;
      if (w_rem >= {1'b0, r_div}) begin
        w_rem    = w_rem - {1'b0, r_div};
        w_quo[0] = 1'b1;
      end
    end
  end

  assign w_sel = r_is_rem ? w_rem[XLEN-1:0] : w_quo;
  assign w_neg = r_is_rem ? r_neg_r : r_neg_q;
  assign w_val = w_neg ? -w_sel : w_sel;
  assign w_fin = r_word ? XLEN'($signed(w_val[31:0])) : w_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_dz || w_ovf) ? DONE : CALC;
        end
      end
      CALC: if (r_cnt == CW'(1)) w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
      w_accept    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      r_word   <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt    <= w_cnt0;
      r_quo    <= w_quo0;
      r_rem    <= '0;
      r_div    <= w_mag_b;
      r_neg_q  <= w_neg_a ^ w_neg_b;
      r_neg_r  <= w_neg_a;
      r_is_rem <= op[1];
      r_word   <= w_wd;
      if (w_dz || w_ovf) r_result <= w_spec;
    end else if (r_state == CALC && !flush) begin
      r_quo <= w_quo;
      r_rem <= w_rem;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_result <= w_fin;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign result    = r_result;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised bench for seq_divider (BPC=1 and BPC=4 side by side).
// Results and latencies are compared against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic        word;
  logic [1:0]  op;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        in_ready, out_valid, busy;
  logic [63:0] result;
  logic        in_ready4, out_valid4, busy4;
  logic [63:0] result4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_divider #(.XLEN(64), .BPC(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  seq_divider #(.XLEN(64), .BPC(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4),
    .op(op), .word(word), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid4), .out_ready(out_ready),
    .result(result4), .busy(busy4)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [1:0] o,
                                      input logic w,
                                      input logic [63:0] a,
                                      input logic [63:0] b);
    if (w)
      return (b[31:0] == 32'h0) ||
             (!o[0] && a[31:0] == 32'h80000000 &&
              b[31:0] == 32'hFFFFFFFF);
    return (b == 64'h0) ||
           (!o[0] && a == 64'h8000000000000000 && b == '1);
  endfunction

  function automatic logic [63:0] ref_res(input logic [1:0] o,
                                          input logic w,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 0) r32 = o[1] ? a32 : 32'hFFFFFFFF;
      else if (!o[0] && a32 == 32'h80000000 && b32 == 32'hFFFFFFFF)
        r32 = o[1] ? 32'h0 : a32;
      else if (!o[0]) begin
        int x, y;
        x = a32;
        y = b32;
        r32 = o[1] ? x % y : x / y;
      end else
        r32 = o[1] ? a32 % b32 : a32 / b32;
      return {{32{r32[31]}}, r32};
    end
    if (b == 0) r = o[1] ? a : '1;
    else if (!o[0] && a == 64'h8000000000000000 && b == '1)
      r = o[1] ? 64'h0 : a;
    else if (!o[0]) begin
      longint x, y;
      x = a;
      y = b;
      r = o[1] ? x % y : x / y;
    end else
      r = o[1] ? a % b : a / b;
    return r;
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic w,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input int bpc);
    if (is_special(o, w, a, b)) return 1;
    return (w ? 32 : 64) / bpc + 1;
  endfunction

  task automatic start_op(input logic [1:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    chk("idle_rdy", {in_ready4, in_ready}, 64'd3);
    op = o; word = w; rs1 = a; rs2 = b;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 2'($urandom);
    word = 1'($urandom);
    rs1 = {$urandom, $urandom};
    rs2 = {$urandom, $urandom};
  endtask

  task automatic do_op(input logic [1:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b);
    logic [63:0] e;
    int lat, l1, l4;
    e = ref_res(o, w, a, b);
    start_op(o, w, a, b);
    lat = 1;
    l1 = out_valid ? 1 : 0;
    l4 = out_valid4 ? 1 : 0;
    while (!(out_valid && out_valid4) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid && l1 == 0) l1 = lat;
      if (out_valid4 && l4 == 0) l4 = lat;
    end
    chk("lat1", 64'(l1), 64'(exp_lat(o, w, a, b, 1)));
    chk("lat4", 64'(l4), 64'(exp_lat(o, w, a, b, 4)));
    chk("res1", result, e);
    chk("res4", result4, e);
  endtask

  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("rel_rdy", {in_ready4, in_ready}, 64'd3);
  endtask

  initial begin
    logic        bad, seen;
    logic [1:0]  o;
    logic        w;
    logic [63:0] a, b;
    int          mode;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    word = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_vld", {out_valid4, out_valid}, 64'd0);
    chk("rst_busy", {busy4, busy}, 64'd0);
    chk("rst_res", result | result4, 64'd0);
    rst = 1'b0;

    do_op(2'b00, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2);
    chk("div_m7_2", result, 64'hFFFFFFFFFFFFFFFD);
    release_op();
    do_op(2'b10, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2);
    chk("rem_m7_2", result, 64'hFFFFFFFFFFFFFFFF);
    release_op();
    do_op(2'b01, 1'b0, 64'h1234, 64'd0);
    release_op();
    do_op(2'b11, 1'b0, 64'h1234, 64'd0);
    chk("remu_dz", result, 64'h1234);
    release_op();
    do_op(2'b00, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF);
    release_op();
    do_op(2'b10, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF);
    release_op();
    do_op(2'b01, 1'b1, 64'h0000000080000000, 64'd1);
    chk("divuw", result4, 64'hFFFFFFFF80000000);
    release_op();

    do_op(2'b01, 1'b0, 64'd100, 64'd7);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (result !== 64'd14 || in_ready !== 1'b0 || !out_valid) bad = 1'b1;
    end
    chk("hold_ok", bad, 1'b0);
    chk("hold_res", result, 64'd14);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = 2'b00; word = 1'b0; rs1 = 64'd50; rs2 = 64'd5;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("hs_rdy", {in_ready4, in_ready}, 64'd3);
    chk("hs_noacc", {busy4, busy, out_valid}, 64'd0);

    for (int k = 0; k < 2; k++) begin
      start_op(2'b00, 1'b0, 64'd123456789, 64'd1000);
      repeat (19) @(posedge clk);
      @(negedge clk);
      if (k == 0) flush = 1'b1;
      else        rst = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk(k == 0 ? "fl_rdy" : "rs_rdy", {in_ready4, in_ready}, 64'd3);
      chk(k == 0 ? "fl_vld" : "rs_vld", out_valid, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
        @(posedge clk);
        #1;
        if (out_valid) seen = 1'b1;
      end
      chk(k == 0 ? "fl_nopulse" : "rs_nopulse", seen, 1'b0);
      do_op(2'b01, 1'b0, 64'd100, 64'd7);
      chk("after_abort", result, 64'd14);
      release_op();
    end

    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 2) == 0);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      mode = $urandom_range(0, 5);
      if (mode == 0) begin
        b = w ? {$urandom, 32'h0} : 64'h0;
      end else if (mode == 1) begin
        a = w ? {$urandom, 32'h80000000} : 64'h8000000000000000;
        b = w ? {$urandom, 32'hFFFFFFFF} : 64'hFFFFFFFFFFFFFFFF;
      end else if (mode == 2) begin
        b = 64'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) b = -b;
      end else if (mode == 3) begin
        a = 64'($urandom_range(0, 1000));
        if ($urandom_range(0, 1) == 1) a = -a;
      end
      do_op(o, w, a, b);
      release_op();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL provide parameter XLEN, default 64, operand/result width; legal values 32 or 64.
REQ-002 SHALL provide parameter BPC, default 1, quotient bits retired per CALC cycle; legal values 1, 2, 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous abort of any in-flight operation.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-009 word  input  1  32-bit W-variant; ignored when XLEN=32.
REQ-010 rs1  input  XLEN  dividend.
REQ-011 rs2  input  XLEN  divisor.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer takes result.
REQ-014 result  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 Accept = in_valid && in_ready at a rising edge; op, word, rs1, rs2 SHALL be captured then and later changes ignored.
REQ-018 Effective width N = 32 when word=1 and XLEN=64, else XLEN; word operands SHALL be rs1[31:0]/rs2[31:0], sign-extended for DIV/REM, zero-extended for DIVU/REMU.
REQ-019 Divide-by-zero (divisor==0 over N bits): quotient = all ones (N bits), remainder = dividend; IDLE->DONE directly, out_valid in cycle after accept.
REQ-020 Signed overflow (DIV/REM, dividend = most-negative N-bit, divisor = -1): quotient = dividend, remainder = 0; IDLE->DONE directly.
REQ-021 Divide-by-zero check SHALL take priority over overflow check.
REQ-022 Otherwise SHALL go IDLE->CALC, run restoring shift-subtract on operand magnitudes, BPC bits per cycle, for exactly N/BPC cycles, then CALC->DONE.
REQ-023 Normal latency: out_valid SHALL rise N/BPC+1 cycles after the accept edge (XLEN=64,BPC=1: 65; word: 33).
REQ-024 Signed fix-up: quotient negated when signed op and operand signs differ; remainder takes dividend sign; unsigned ops no fix-up.
REQ-025 Word results SHALL be 32-bit results sign-extended to XLEN for all four ops.
REQ-026 In DONE, result SHALL be held stable while out_ready=0; out_valid && out_ready SHALL return to IDLE, in_ready high next cycle.
REQ-027 A new request SHALL NOT be accepted in the same cycle as a result handshake.
REQ-028 flush=1 in any state SHALL force IDLE at next edge, discard in-flight result, and block acceptance that cycle; flush wins over out_ready and in_valid.
REQ-029 Invariant: for non-special cases, dividend = quotient*divisor + remainder, |remainder| < |divisor|.

Reset
REQ-030 rst SHALL asynchronously force state IDLE, out_valid=0, busy=0, in_ready=1 after release, result=0, internal counters/accumulators=0.
REQ-031 rst asserted mid-CALC or in DONE SHALL abandon the operation with no out_valid pulse.

Verification
REQ-032 XLEN=64,BPC=1: DIV rs1=0xFFFFFFFFFFFFFFF9 (-7), rs2=2 -> result 0xFFFFFFFFFFFFFFFD (-3) 65 cycles after accept; REM same operands -> 0xFFFFFFFFFFFFFFFF (-1).
REQ-033 DIVU rs1=0x1234, rs2=0 -> 0xFFFFFFFFFFFFFFFF one cycle after accept; REMU -> 0x1234.
REQ-034 DIV rs1=0x8000000000000000, rs2=0xFFFFFFFFFFFFFFFF -> 0x8000000000000000, one-cycle latency; REM -> 0.
REQ-035 word=1 DIVU rs1=0x0000000080000000, rs2=1 -> 0xFFFFFFFF80000000 after 33 cycles; BPC=4 rerun -> same value after 9 cycles.
REQ-036 Hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0; assert out_ready -> IDLE, in_ready=1 next cycle, in_valid in handshake cycle not accepted.
REQ-037 flush on 20th CALC cycle, then separately rst on 20th CALC cycle -> no out_valid pulse, in_ready=1 next cycle, following DIVU 100/7 -> 14.
